// File: rtl/ps2_device_tx.sv
// ---------------------------------------------------------------------------
// ps2_device_tx
//
// Device-side (keyboard end) PS/2 transmitter. Sends one byte to a PS/2 host
// as an 11-bit frame: start 0, d0..d7 LSB first, odd parity, stop 1. The
// block generates the PS/2 clock itself. Both bus lines are open-drain: they
// are only ever pulled to 0 or released to z.
//
// If the host inhibits the bus (holds clk low) during the high phase of any
// bit before the stop bit, the frame is dropped. o_aborted pulses and the same
// byte is retried automatically once the bus has been idle again.
//
// Parameters
//   CLKS_PER_HALF  i_clk cycles per PS/2 clock half-period
//   IDLE_CLKS      cycles both lines must read high before a frame may start
//   SYNC_STAGES    synchroniser depth on each line readback (>= 2)
//
// Ports
//   i_clk        in     system clock, rising edge
//   i_rst        in     synchronous active-high reset
//   i_data[7:0]  in     byte to send, sampled when a request is accepted
//   i_send       in     send request, accepted only while o_busy = 0
//   io_PS2_clk   inout  open-drain PS/2 clock
//   io_PS2_data  inout  open-drain PS/2 data
//   o_busy       out    high from the cycle after acceptance until o_done
//   o_done       out    one-cycle pulse when the stop bit completes
//   o_aborted    out    one-cycle pulse for each host-inhibited frame
// ---------------------------------------------------------------------------
module ps2_device_tx #(
    parameter int CLKS_PER_HALF = 600,
    parameter int IDLE_CLKS     = 600,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_send,
    inout  logic       io_PS2_clk,
    inout  logic       io_PS2_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_aborted
);

    localparam int CNT_W  = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
    localparam int IDLE_W = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_HALF - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);

    // Bit index of the parity bit; the stop bit follows it.
    localparam logic [3:0] IDX_PARITY = 4'd9;
    localparam logic [3:0] IDX_STOP   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_HIGH,
        S_LOW,
        S_STOP_REL,
        S_ABORT
    } state_t;

    state_t                  r_state;
    logic [10:0]             r_frame;      // {stop, parity, d7..d0, start}
    logic [3:0]              r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDLE_W-1:0]       r_idle;
    logic                    r_clk_oe;     // 1 = pull PS/2 clock low
    logic                    r_data_oe;    // 1 = pull PS/2 data low
    logic                    r_busy;
    logic                    r_done;
    logic                    r_aborted;

    logic [SYNC_STAGES-1:0]  r_clk_sync;
    logic [SYNC_STAGES-1:0]  r_data_sync;

    logic                    w_clk_hi;
    logic                    w_data_hi;
    logic                    w_half_last;
    logic [3:0]              w_next_idx;

    // Open-drain drivers: a line is either pulled low or left floating.
    assign io_PS2_clk  = r_clk_oe  ? 1'b0 : 1'bz;
    assign io_PS2_data = r_data_oe ? 1'b0 : 1'bz;

    assign w_clk_hi    = r_clk_sync[SYNC_STAGES-1];
    assign w_data_hi   = r_data_sync[SYNC_STAGES-1];
    assign w_half_last = (r_cnt == CNT_LAST);
    assign w_next_idx  = r_idx + 4'd1;

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_aborted = r_aborted;

    // Line readback synchronisers. Preset to 1 so that a freshly reset block
    // sees an idle bus rather than a phantom inhibit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0],  io_PS2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], io_PS2_data};
        end
    end

    // Frame FSM. All line enables and status outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_cnt     <= '0;
            r_idle    <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (i_send) begin
                        // XNOR-reduce gives 1 when d0..d7 hold an even number
                        // of ones, which is what makes the total odd.
                        r_frame <= {1'b1, ~^i_data, i_data, 1'b0};
                        r_busy  <= 1'b1;
                        r_idle  <= '0;
                        r_state <= S_WAIT_BUS;
                    end
                end

                S_WAIT_BUS: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_clk_hi && w_data_hi) begin
                        if (r_idle == IDLE_LAST) begin
                            // Bus idle long enough: present the start bit.
                            r_idle    <= '0;
                            r_idx     <= 4'd0;
                            r_cnt     <= '0;
                            r_data_oe <= ~r_frame[0];
                            r_state   <= S_HIGH;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
                    end else begin
                        r_idle <= '0;
                    end
                end

                S_HIGH: begin
                    if (w_half_last) begin
                        r_cnt <= '0;
                        // A low clock at the end of our own high phase means
                        // the host is inhibiting. Once the stop bit is on the
                        // wire the byte counts as delivered.
                        if (!w_clk_hi && (r_idx <= IDX_PARITY)) begin
                            r_data_oe <= 1'b0;
                            r_aborted <= 1'b1;
                            r_state   <= S_ABORT;
                        end else begin
                            r_clk_oe <= 1'b1;
                            r_state  <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_LOW: begin
                    if (w_half_last) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b0;
                        if (r_idx < IDX_STOP) begin
                            r_idx     <= w_next_idx;
                            r_data_oe <= ~r_frame[w_next_idx];
                            r_state   <= S_HIGH;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_STOP_REL;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STOP_REL: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_half_last) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_ABORT: begin
                    // Retry the same latched frame; o_busy stays high.
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_idle    <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT_BUS;
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
module tb_ps2_device_tx;

    localparam int CPH  = 8;
    localparam int IDLE = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy, done, aborted;
    wire        ps2_clk, ps2_data;

    logic host_clk_low  = 1'b0;
    logic host_data_low = 1'b0;

    assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = host_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_device_tx #(
        .CLKS_PER_HALF (CPH),
        .IDLE_CLKS     (IDLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_send      (send),
        .io_PS2_clk  (ps2_clk),
        .io_PS2_data (ps2_data),
        .o_busy      (busy),
        .o_done      (done),
        .o_aborted   (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Host model: samples data on every clock fall it did not cause itself.
    bit rx_bits[$];
    int nfalls = 0, first_fall_cyc = -1;
    int done_cnt = 0, abort_cnt = 0, busy_cnt = 0, done_busy = 0;
    bit prev_clk_v = 1'b1;

    always @(negedge clk) begin
        bit cv, dv;
        cv = (ps2_clk !== 1'b0);
        dv = (ps2_data !== 1'b0);
        if (prev_clk_v && !cv && !host_clk_low) begin
            rx_bits.push_back(dv);
            if (nfalls == 0) first_fall_cyc = cyc;
            nfalls++;
        end
        prev_clk_v = cv;
        if (done === 1'b1) done_cnt++;
        if (aborted === 1'b1) abort_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1 && busy === 1'b1) done_busy++;
    end

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic logic [10:0] rx_word();
        logic [10:0] w;
        w = '0;
        for (int i = 0; i < rx_bits.size() && i < 11; i++) w[i] = rx_bits[i];
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_mon();
        rx_bits.delete();
        nfalls = 0; first_fall_cyc = -1;
        done_cnt = 0; abort_cnt = 0; busy_cnt = 0; done_busy = 0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; send = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy/done/abort=%b%b%b exp=000", busy, done, aborted);
        end
        n_tests++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_lines got clk/data=%b%b exp=11", ps2_clk, ps2_data);
        end
    endtask

    task automatic test_frame_1c();
        logic [10:0] exp;
        bit ok;
        int t_req;
        clear_mon();
        exp = model_frame(8'h1C);
        tick(); data = 8'h1C; send = 1'b1; t_req = cyc;
        tick(); send = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL f1c_busy_rise got=%b exp=1", busy);
        end
        wait_done(1000, ok);
        repeat (5) tick();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL f1c_done_timeout got=no_done exp=done");
        end
        n_tests++;
        if (rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL f1c_bits got n=%0d w=%b exp n=11 w=%b", rx_bits.size(), rx_word(), exp);
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL f1c_done_count got=%0d exp=1", done_cnt);
        end
        n_tests++;
        if (busy_cnt != 1 + IDLE + 22*CPH + CPH - 1) begin
            n_fail++;
            $display("FAIL f1c_busy_cycles got=%0d exp=%0d", busy_cnt, 1 + IDLE + 22*CPH + CPH - 1);
        end
        n_tests++;
        if (first_fall_cyc - t_req != 1 + IDLE + CPH) begin
            n_fail++;
            $display("FAIL f1c_latency got=%0d exp=%0d", first_fall_cyc - t_req, 1 + IDLE + CPH);
        end
        n_tests++;
        if (done_busy != 0) begin
            n_fail++;
            $display("FAIL f1c_busy_drop_with_done got=%0d exp=0", done_busy);
        end
    endtask

    task automatic test_random_bytes();
        logic [7:0]  b;
        logic [10:0] exp, got;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      b = 8'h00;
            else if (k == 1) b = 8'hFF;
            else             b = 8'($urandom_range(0, 255));
            exp = model_frame(b);
            clear_mon();
            tick(); data = b; send = 1'b1;
            tick(); send = 1'b0;
            wait_done(1000, ok);
            repeat (3) tick();
            got = rx_word();
            n_tests++;
            if (!ok || done_cnt != 1 || rx_bits.size() != 11 || got !== exp) begin
                n_fail++;
                $display("FAIL rnd_frame byte=%h got ok=%0d done=%0d n=%0d w=%b exp w=%b",
                         b, ok, done_cnt, rx_bits.size(), got, exp);
            end
            n_tests++;
            if (got[8:1] !== b) begin
                n_fail++;
                $display("FAIL rnd_keycode got=%h exp=%h", got[8:1], b);
            end
        end
    endtask

    task automatic test_inhibit_retry();
        logic [10:0] exp;
        bit ok;
        int t_rel, i;
        clear_mon();
        exp = model_frame(8'h1C);
        tick(); data = 8'h1C; send = 1'b1;
        tick(); send = 1'b0;
        for (i = 0; i < 500 && nfalls < 4; i++) tick();
        for (i = 0; i < 50 && ps2_clk === 1'b0; i++) tick();
        tick();
        host_clk_low = 1'b1;
        for (i = 0; i < 50 && abort_cnt == 0; i++) tick();
        n_tests++;
        if (abort_cnt != 1) begin
            n_fail++;
            $display("FAIL inh_abort_pulse got=%0d exp=1", abort_cnt);
        end
        tick();
        n_tests++;
        if (ps2_data !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL inh_release got data/busy=%b%b exp=11", ps2_data, busy);
        end
        repeat (20) tick();
        rx_bits.delete(); nfalls = 0; first_fall_cyc = -1;
        t_rel = cyc;
        host_clk_low = 1'b0;
        wait_done(1000, ok);
        repeat (5) tick();
        n_tests++;
        if (!ok || rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL inh_resend got ok=%0d n=%0d w=%b exp w=%b", ok, rx_bits.size(), rx_word(), exp);
        end
        n_tests++;
        if (done_cnt != 1 || abort_cnt != 1) begin
            n_fail++;
            $display("FAIL inh_counts got done=%0d abort=%0d exp 1 1", done_cnt, abort_cnt);
        end
        // synchroniser delay, then the idle window, then the first high half
        n_tests++;
        if (first_fall_cyc - t_rel != SYNC + IDLE + CPH) begin
            n_fail++;
            $display("FAIL inh_restart_latency got=%0d exp=%0d", first_fall_cyc - t_rel, SYNC + IDLE + CPH);
        end
    endtask

    task automatic test_data_held_low();
        logic [10:0] exp;
        bit ok;
        int t_rel;
        clear_mon();
        exp = model_frame(8'h1C);
        host_data_low = 1'b1;
        repeat (5) tick();
        data = 8'h1C; send = 1'b1;
        tick(); send = 1'b0;
        repeat (40) tick();
        n_tests++;
        if (nfalls != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_no_clock got falls=%0d busy=%b exp 0 1", nfalls, busy);
        end
        t_rel = cyc;
        host_data_low = 1'b0;
        wait_done(1000, ok);
        repeat (3) tick();
        n_tests++;
        if (first_fall_cyc - t_rel != SYNC + IDLE + CPH) begin
            n_fail++;
            $display("FAIL hold_start_latency got=%0d exp=%0d", first_fall_cyc - t_rel, SYNC + IDLE + CPH);
        end
        n_tests++;
        if (!ok || rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL hold_frame got ok=%0d n=%0d w=%b exp w=%b", ok, rx_bits.size(), rx_word(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        bit ok;
        clear_mon();
        exp = model_frame(8'h1C);
        tick(); data = 8'h1C; send = 1'b1;
        tick(); send = 1'b0;
        for (int i = 0; i < 500 && nfalls < 3; i++) tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_mid got=%b exp=1", busy);
        end
        data = 8'h5A; send = 1'b1;
        tick(); send = 1'b0;
        wait_done(1000, ok);
        repeat (3) tick();
        n_tests++;
        if (!ok || done_cnt != 1 || rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL b2b_ignored got ok=%0d done=%0d n=%0d w=%b exp w=%b",
                     ok, done_cnt, rx_bits.size(), rx_word(), exp);
        end
        clear_mon();
        exp = model_frame(8'h5A);
        data = 8'h5A; send = 1'b1;
        tick(); send = 1'b0;
        wait_done(1000, ok);
        repeat (3) tick();
        n_tests++;
        if (!ok || rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL b2b_second got ok=%0d n=%0d w=%b exp w=%b", ok, rx_bits.size(), rx_word(), exp);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  b;
        logic [10:0] exp;
        bit ok;
        clear_mon();
        tick(); data = 8'h1C; send = 1'b1;
        tick(); send = 1'b0;
        for (int i = 0; i < 500 && nfalls < 7; i++) tick();
        tick();
        n_tests++;
        if (ps2_clk !== 1'b0 || ps2_data !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_bit6_driven got clk/data=%b%b exp=00", ps2_clk, ps2_data);
        end
        rst = 1'b1;
        tick(); rst = 1'b0;
        n_tests++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release got clk/data/busy=%b%b%b exp=110", ps2_clk, ps2_data, busy);
        end
        repeat (40) tick();
        n_tests++;
        if (done_cnt != 0 || abort_cnt != 0 || rx_bits.size() != 7) begin
            n_fail++;
            $display("FAIL rstmid_incomplete got done=%0d abort=%0d n=%0d exp 0 0 7",
                     done_cnt, abort_cnt, rx_bits.size());
        end
        b = 8'($urandom_range(0, 255));
        exp = model_frame(b);
        clear_mon();
        data = b; send = 1'b1;
        tick(); send = 1'b0;
        wait_done(1000, ok);
        repeat (3) tick();
        n_tests++;
        if (!ok || done_cnt != 1 || rx_bits.size() != 11 || rx_word() !== exp) begin
            n_fail++;
            $display("FAIL rstmid_next byte=%h got ok=%0d n=%0d w=%b exp w=%b",
                     b, ok, rx_bits.size(), rx_word(), exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame_1c();
        test_random_bytes();
        test_inhibit_retry();
        test_data_held_low();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
